// File: rtl/ifu_if.sv
// Instruction-memory read channel between the fetch unit and memory.
// Carries the AXI4-Lite-style AR and R signals only; the fetch unit has no write side.
interface ifu_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] araddr;
    logic             arvalid;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read per PC update, with the result
// handed to decode over a valid/ready handshake.
module ifu #(
    parameter int unsigned WIDTH       = 32,
    parameter bit          RESET_FETCH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_update,
    ifu_if.master            bus,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             busy
);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StFault, StHold} state_e;

    state_e           state_q, state_d;
    logic             boot_q, boot_d;
    logic             run_q;
    logic [WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]      inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic             inst_fault_q, inst_fault_d;

    always_comb begin
        state_d      = state_q;
        boot_d       = boot_q;
        araddr_d     = araddr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        unique case (state_q)
            StIdle: begin
                // run_q holds off the first launch until one edge after reset release.
                if (run_q && (pc_update || boot_q)) begin
                    boot_d    = 1'b0;
                    araddr_d  = pc;
                    inst_pc_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        inst_d       = 32'h0;
                        inst_fault_d = 1'b1;
                        state_d      = StFault;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (bus.arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bus.rvalid) begin
                    inst_fault_d = (bus.rresp != 2'b00);
                    inst_d       = (bus.rresp == 2'b00) ? bus.rdata : 32'h0;
                    state_d      = StHold;
                end
            end
            // Misaligned fetch: one bus-free cycle so the fault shows with fixed latency.
            StFault: begin
                state_d = StHold;
            end
            StHold: begin
                if (inst_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            boot_q       <= RESET_FETCH;
            run_q        <= 1'b0;
            araddr_q     <= '0;
            inst_q       <= 32'h0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            run_q        <= 1'b1;
            araddr_q     <= araddr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    assign bus.araddr  = araddr_q;
    assign bus.arvalid = (state_q == StAddr);
    assign bus.rready  = (state_q == StData);
    assign inst_valid  = (state_q == StHold);
    assign busy        = (state_q != StIdle);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_fault  = inst_fault_q;

endmodule
